countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Parametrised HH:MM:SS BCD countdown timer with user editing, start/pause, and an alarm phase on expiry.
- Takes raw push-buttons (up/down/left/right/start/load), debounces them internally, and generates its own 1 Hz tick from the system clock.
- Sits beside the time-of-day clock; its BCD digit outputs feed the shared 7-segment display mux.
- Can preset from the time-of-day digit bus or be edited field by field.

Parameters:
- CLK_HZ, 50_000_000, system clock cycles per 1 s tick.
- DEB_CYCLES, 1_000_000, cycles a raw button must be stable before its level is accepted.
- HR_MAX, 23, maximum hour value accepted by edit/load, 1..99.
- ALARM_SECS, 10, seconds the alarm stays asserted in DONE before auto-return to IDLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- up, down, left, right, start, load  in  1 each  raw asynchronous buttons, active-high.
- hr_10, hr_1, min_10, min_1, sec_10, sec_1  in  4 each  BCD preset bus, used on load.
- hr_2_10, hr_2_1, min_2_10, min_2_1, sec_2_10, sec_2_1  out  4 each  current countdown value, BCD.
- cursor  out  2  edit field: 0 = sec, 1 = min, 2 = hr.
- running  out  1  high in RUN.
- alarm  out  1  high in DONE.

Behaviour:
- Reset (reset = 0, asynchronous): all digits 0, cursor = 0, FSM = IDLE, running = 0, alarm = 0, prescaler = 0, debouncers cleared.
- Buttons:
  - Each raw input passes through a 2-flop synchroniser, then a stability counter.
  - The accepted level changes only after DEB_CYCLES consecutive equal samples.
  - A rising edge of the accepted level produces a one-cycle press pulse.
  - Holding a button produces no repeats.
- Tick:
  - The prescaler counts 0..CLK_HZ-1 only in RUN and DONE; tick pulses for one cycle when it wraps.
  - The prescaler is cleared on entry to RUN and on entry to IDLE.
  - The first decrement therefore occurs exactly CLK_HZ cycles after the start press is accepted.
- States:
  - IDLE:
    - up/down inc/dec the field selected by cursor, wrapping: sec and min 0..59, hr 0..HR_MAX.
    - Other fields are unaffected; there is no carry while editing.
    - left/right move cursor: right = cursor-1, left = cursor+1, wrapping within 0..2.
    - load copies the preset bus. Any hour above HR_MAX saturates to HR_MAX; minute or second fields above 59 saturate to 59.
    - start goes to RUN only if the value is non-zero; otherwise it is ignored.
  - RUN:
    - On tick, decrement with borrow: sec wraps 0→59 borrowing from min, min wraps 0→59 borrowing from hr.
    - A tick that produces 00:00:00 moves to DONE on the same edge as the digits update.
    - start → PAUSE. up/down/left/right/load are ignored.
  - PAUSE:
    - Value is held; the prescaler is held, not cleared.
    - start → RUN and resumes the partial second.
    - load → IDLE with the preset loaded.
    - Other buttons are ignored.
  - DONE:
    - alarm = 1 and digits stay 00:00:00.
    - The prescaler counts seconds; after ALARM_SECS ticks → IDLE.
    - Any press → IDLE immediately.
    - Both paths clear alarm; digits remain 0.
- Priority when several press pulses coincide in one cycle: start > load > up > down > left > right. Only the highest-priority pulse acts.
- All outputs are registered. Digit and FSM changes appear on the clk edge after the press pulse (2 + DEB_CYCLES + 1 cycles after the raw edge settles).
- BCD arithmetic: each digit is always 0..9 and the tens digit of min/sec is always 0..5. Invalid codes are never produced.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, RUN, PAUSE, DONE.
  - Cursor field constants: F_SEC = 0, F_MIN = 1, F_HR = 2.
  - BCD limit constants: 5/9 for min/sec tens/units.
  - A BCD 2-digit inc/dec-with-wrap function taking the upper limit.
- One sub-module, btn_debounce (parameter DEB_CYCLES), instantiated six times. It contains the synchroniser, stability counter and press-pulse output.
- The FSM, prescaler and digit datapath stay in countdown_timer.

Test Plan (CLK_HZ = 10, DEB_CYCLES = 3, HR_MAX = 23, ALARM_SECS = 2):
- Reset then load preset 00:01:02, press start → running = 1. Digits read 00:01:01 after 10 cycles, 00:00:59 after 30 cycles, 00:00:00 plus alarm = 1 after 620 cycles.
- Load 01:00:00 and run one tick → 00:59:59. Separately load 25:75:99 → saturates to 23:59:59.
- In IDLE, cursor = 0 at 00:00:59, press up → 00:00:00 with min unchanged. Press left twice, then down → hr wraps to 23.
- Run 00:00:05, pause after 15 cycles (00:00:04 plus 5 cycles into the second), hold 50 cycles. Resume → 00:00:03 appears 5 cycles later.
- Reach DONE, press nothing → alarm drops and FSM returns to IDLE after 20 cycles. Repeat with a down press in DONE → IDLE next cycle.
- Glitchy start (pulses shorter than 3 cycles) → no state change. Assert reset mid-RUN → all outputs 0 asynchronously and FSM = IDLE. Press start with 00:00:00 → stays IDLE.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types, constants and BCD helpers for the countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] F_SEC = 2'd0;
  localparam logic [1:0] F_MIN = 2'd1;
  localparam logic [1:0] F_HR  = 2'd2;

  localparam int unsigned MS_TENS_MAX = 5;
  localparam int unsigned UNITS_MAX   = 9;
  localparam logic [6:0]  MS_MAX      = 7'(MS_TENS_MAX * 10 + UNITS_MAX);

  function automatic logic [7:0] bcd2_to_bin(input logic [7:0] v);
    return ({4'b0, v[7:4]} * 8'd10) + {4'b0, v[3:0]};
  endfunction

  function automatic logic [7:0] bin_to_bcd2(input logic [7:0] b);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = b / 8'd10;
    units = b % 8'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  // Two-digit BCD increment/decrement wrapping within 0..max.
  function automatic logic [7:0] bcd2_step(input logic [7:0] v,
                                           input logic [6:0] max,
                                           input logic       dec);
    logic [7:0] b;
    logic [7:0] m;
    b = bcd2_to_bin(v);
    m = {1'b0, max};
    if (dec) b = (b == 8'd0) ? m : b - 8'd1;
    else     b = (b >= m) ? 8'd0 : b + 8'd1;
    return bin_to_bcd2(b);
  endfunction

  // Clamp a preset field to max; the result is always valid BCD.
  function automatic logic [7:0] bcd2_sat(input logic [7:0] v,
                                          input logic [6:0] max);
    logic [7:0] b;
    b = bcd2_to_bin(v);
    if (b > {1'b0, max}) b = {1'b0, max};
    return bin_to_bcd2(b);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button synchroniser, stability filter and rising-edge press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level once it has been sampled DEB_CYCLES times in a row.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync2_q;
      else                              cnt_d   = cnt_q + 1'b1;
    end
  end

  // Synchroniser, filter state and edge-detect history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS BCD countdown timer with field editing, pause and timed alarm.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int HR_MAX     = 23,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       load,
  input  logic [3:0] hr_10,
  input  logic [3:0] hr_1,
  input  logic [3:0] min_10,
  input  logic [3:0] min_1,
  input  logic [3:0] sec_10,
  input  logic [3:0] sec_1,
  output logic [3:0] hr_2_10,
  output logic [3:0] hr_2_1,
  output logic [3:0] min_2_10,
  output logic [3:0] min_2_1,
  output logic [3:0] sec_2_10,
  output logic [3:0] sec_2_1,
  output logic [1:0] cursor,
  output logic       running,
  output logic       alarm
);

  localparam int         PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int         AW   = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [6:0] HMAX = 7'(HR_MAX);

  // Press pulses: [0]=up [1]=down [2]=left [3]=right [4]=start [5]=load
  logic [5:0] raw, press;
  assign raw = {load, start, right, left, down, up};

  for (genvar g = 0; g < 6; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i  (clk),
      .rst_ni (reset),
      .btn_i  (raw[g]),
      .press_o(press[g])
    );
  end

  state_e        state_q, state_d;
  logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [1:0]    cursor_q, cursor_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] alm_q, alm_d;
  logic          running_q, alarm_q;
  logic          tick;
  logic [7:0]    hr_ld, min_ld, sec_ld;
  logic [7:0]    hr_dn, min_dn, sec_dn;

  assign hr_ld  = bcd2_sat({hr_10, hr_1}, HMAX);
  assign min_ld = bcd2_sat({min_10, min_1}, MS_MAX);
  assign sec_ld = bcd2_sat({sec_10, sec_1}, MS_MAX);

  // One-second decrement with borrow into minutes and hours.
  always_comb begin
    sec_dn = bcd2_step(sec_q, MS_MAX, 1'b1);
    min_dn = (sec_q == 8'h00) ? bcd2_step(min_q, MS_MAX, 1'b1) : min_q;
    hr_dn  = (sec_q == 8'h00 && min_q == 8'h00) ? bcd2_step(hr_q, HMAX, 1'b1) : hr_q;
  end

  // Next-state, prescaler and digit datapath; pulses are priority-ordered.
  always_comb begin
    state_d  = state_q;
    hr_d     = hr_q;
    min_d    = min_q;
    sec_d    = sec_q;
    cursor_d = cursor_q;
    alm_d    = alm_q;
    presc_d  = presc_q;
    tick     = 1'b0;
    if (state_q == RUN || state_q == DONE) begin
      tick    = (presc_q == PW'(CLK_HZ - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (press[4]) begin
          if ({hr_q, min_q, sec_q} != '0) state_d = RUN;
        end else if (press[5]) begin
          hr_d  = hr_ld;
          min_d = min_ld;
          sec_d = sec_ld;
        end else if (press[0] || press[1]) begin
          unique case (cursor_q)
            F_SEC:   sec_d = bcd2_step(sec_q, MS_MAX, press[1] & ~press[0]);
            F_MIN:   min_d = bcd2_step(min_q, MS_MAX, press[1] & ~press[0]);
            default: hr_d  = bcd2_step(hr_q, HMAX, press[1] & ~press[0]);
          endcase
        end else if (press[2]) begin
          cursor_d = (cursor_q == F_HR) ? F_SEC : cursor_q + 2'd1;
        end else if (press[3]) begin
          cursor_d = (cursor_q == F_SEC) ? F_HR : cursor_q - 2'd1;
        end
      end
      RUN: begin
        if (press[4]) state_d = PAUSE;
        if (tick) begin
          hr_d  = hr_dn;
          min_d = min_dn;
          sec_d = sec_dn;
          if ({hr_dn, min_dn, sec_dn} == '0) begin
            state_d = DONE;
            alm_d   = '0;
          end
        end
      end
      PAUSE: begin
        presc_d = presc_q;
        if (press[4]) begin
          state_d = RUN;
        end else if (press[5]) begin
          state_d = IDLE;
          presc_d = '0;
          hr_d    = hr_ld;
          min_d   = min_ld;
          sec_d   = sec_ld;
        end
      end
      DONE: begin
        if (|press) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (tick) begin
          if (alm_q == AW'(ALARM_SECS - 1)) begin
            state_d = IDLE;
            presc_d = '0;
          end else begin
            alm_d = alm_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, digit, prescaler and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hr_q      <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      cursor_q  <= F_SEC;
      presc_q   <= '0;
      alm_q     <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      cursor_q  <= cursor_d;
      presc_q   <= presc_d;
      alm_q     <= alm_d;
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == DONE);
    end
  end

  assign {hr_2_10, hr_2_1}   = hr_q;
  assign {min_2_10, min_2_1} = min_q;
  assign {sec_2_10, sec_2_1} = sec_q;
  assign cursor  = cursor_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: table-driven editing vectors plus timed run sequences.
module tb_countdown_timer;

  localparam logic [5:0] B_UP    = 6'b000001;
  localparam logic [5:0] B_DOWN  = 6'b000010;
  localparam logic [5:0] B_LEFT  = 6'b000100;
  localparam logic [5:0] B_RIGHT = 6'b001000;
  localparam logic [5:0] B_START = 6'b010000;
  localparam logic [5:0] B_LOAD  = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  btn;
  logic [23:0] pre;
  logic [3:0]  hr_2_10, hr_2_1, min_2_10, min_2_1, sec_2_10, sec_2_1;
  logic [1:0]  cursor;
  logic        running, alarm;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.CLK_HZ(10), .DEB_CYCLES(3), .HR_MAX(23), .ALARM_SECS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .up      (btn[0]),
    .down    (btn[1]),
    .left    (btn[2]),
    .right   (btn[3]),
    .start   (btn[4]),
    .load    (btn[5]),
    .hr_10   (pre[23:20]),
    .hr_1    (pre[19:16]),
    .min_10  (pre[15:12]),
    .min_1   (pre[11:8]),
    .sec_10  (pre[7:4]),
    .sec_1   (pre[3:0]),
    .hr_2_10 (hr_2_10),
    .hr_2_1  (hr_2_1),
    .min_2_10(min_2_10),
    .min_2_1 (min_2_1),
    .sec_2_10(sec_2_10),
    .sec_2_1 (sec_2_1),
    .cursor  (cursor),
    .running (running),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  btn;
    logic [23:0] preset;
    logic [27:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [27:0] exp;
  } sb_t;

  vec_t tbl[18];
  sb_t  sbq[$];

  function automatic logic [27:0] ev(input int hh, input int mm, input int ss,
                                     input int cur, input logic run, input logic alm);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10), 2'(cur), run, alm};
  endfunction

  function automatic logic [23:0] pv(input int hh, input int mm, input int ss);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [27:0] snap();
    return {hr_2_10, hr_2_1, min_2_10, min_2_1, sec_2_10, sec_2_1, cursor, running, alarm};
  endfunction

  task automatic sb_push(input string n, input logic [27:0] e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  task automatic observe();
    sb_t s;
    logic [27:0] got;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got an observation with no expected entry");
    end else begin
      s   = sbq.pop_front();
      got = snap();
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h (hhmmss|cur|run|alarm)", s.name, got, s.exp);
      end
    end
  endtask

  // Raise the buttons at a falling edge; the FSM acts on the 6th rising edge.
  task automatic press(input logic [5:0] m);
    @(negedge clk);
    btn = m;
    repeat (6) @(posedge clk);
    #1;
    btn = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_after(input string n, input int cyc, input logic [27:0] e);
    sb_push(n, e);
    cycles(cyc);
    observe();
  endtask

  task automatic chk_press(input string n, input logic [5:0] m, input logic [27:0] e);
    sb_push(n, e);
    press(m);
    observe();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{"ld_00_00_59",  B_LOAD,           pv(0, 0, 59),  ev(0, 0, 59, 0, 0, 0)};
    tbl[1]  = '{"up_sec_wrap",  B_UP,             '0,            ev(0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{"left_1",       B_LEFT,           '0,            ev(0, 0, 0, 1, 0, 0)};
    tbl[3]  = '{"left_2",       B_LEFT,           '0,            ev(0, 0, 0, 2, 0, 0)};
    tbl[4]  = '{"down_hr_wrap", B_DOWN,           '0,            ev(23, 0, 0, 2, 0, 0)};
    tbl[5]  = '{"up_hr_wrap",   B_UP,             '0,            ev(0, 0, 0, 2, 0, 0)};
    tbl[6]  = '{"left_wrap",    B_LEFT,           '0,            ev(0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{"right_wrap",   B_RIGHT,          '0,            ev(0, 0, 0, 2, 0, 0)};
    tbl[8]  = '{"right_1",      B_RIGHT,          '0,            ev(0, 0, 0, 1, 0, 0)};
    tbl[9]  = '{"down_min",     B_DOWN,           '0,            ev(0, 59, 0, 1, 0, 0)};
    tbl[10] = '{"ld_saturate",  B_LOAD,           pv(25, 75, 99), ev(23, 59, 59, 1, 0, 0)};
    tbl[11] = '{"up_min_wrap",  B_UP,             '0,            ev(23, 0, 59, 1, 0, 0)};
    tbl[12] = '{"right_0",      B_RIGHT,          '0,            ev(23, 0, 59, 0, 0, 0)};
    tbl[13] = '{"down_sec",     B_DOWN,           '0,            ev(23, 0, 58, 0, 0, 0)};
    tbl[14] = '{"prio_up_left", B_UP | B_LEFT,    '0,            ev(23, 0, 59, 0, 0, 0)};
    tbl[15] = '{"prio_ld_up",   B_LOAD | B_UP,    pv(12, 34, 56), ev(12, 34, 56, 0, 0, 0)};
    tbl[16] = '{"prio_l_r",     B_LEFT | B_RIGHT, '0,            ev(12, 34, 56, 1, 0, 0)};
    tbl[17] = '{"right_back",   B_RIGHT,          '0,            ev(12, 34, 56, 0, 0, 0)};

    btn   = '0;
    pre   = '0;
    reset = 1'b0;
    chk_after("reset_state", 3, ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    cycles(4);

    for (int unsigned i = 0; i < 18; i++) begin
      pre = tbl[i].preset;
      chk_press(tbl[i].name, tbl[i].btn, tbl[i].exp);
      cycles(6);
    end

    // Full countdown 00:01:02 into DONE, then auto-return after two alarm seconds.
    pre = pv(0, 1, 2);
    chk_press("s1_load", B_LOAD, ev(0, 1, 2, 0, 0, 0));
    cycles(6);
    chk_press("s1_start", B_START, ev(0, 1, 2, 0, 1, 0));
    chk_after("s1_t10", 10, ev(0, 1, 1, 0, 1, 0));
    chk_after("s1_t30", 20, ev(0, 0, 59, 0, 1, 0));
    chk_after("s1_t619", 589, ev(0, 0, 1, 0, 1, 0));
    chk_after("s1_t620_done", 1, ev(0, 0, 0, 0, 0, 1));
    chk_after("s1_alarm_hold", 19, ev(0, 0, 0, 0, 0, 1));
    chk_after("s1_auto_idle", 1, ev(0, 0, 0, 0, 0, 0));
    cycles(6);

    // Hour borrow, pause, and load from PAUSE.
    pre = pv(1, 0, 0);
    chk_press("s2_load", B_LOAD, ev(1, 0, 0, 0, 0, 0));
    cycles(6);
    chk_press("s2_start", B_START, ev(1, 0, 0, 0, 1, 0));
    chk_after("s2_borrow", 10, ev(0, 59, 59, 0, 1, 0));
    chk_press("s2_pause", B_START, ev(0, 59, 59, 0, 0, 0));
    cycles(6);
    pre = pv(0, 0, 5);
    chk_press("s2_pause_load", B_LOAD, ev(0, 0, 5, 0, 0, 0));
    cycles(6);

    // Partial second survives a pause; then DONE left early by a down press.
    chk_press("s3_start", B_START, ev(0, 0, 5, 0, 1, 0));
    cycles(9);
    chk_press("s3_pause_t15", B_START, ev(0, 0, 4, 0, 0, 0));
    chk_after("s3_pause_hold", 50, ev(0, 0, 4, 0, 0, 0));
    chk_press("s3_resume", B_START, ev(0, 0, 4, 0, 1, 0));
    chk_after("s3_resume_r4", 4, ev(0, 0, 4, 0, 1, 0));
    chk_after("s3_resume_r5", 1, ev(0, 0, 3, 0, 1, 0));
    chk_after("s3_done", 30, ev(0, 0, 0, 0, 0, 1));
    chk_press("s3_down_exit", B_DOWN, ev(0, 0, 0, 0, 0, 0));
    cycles(6);

    // Two-cycle start glitch is filtered out.
    pre = pv(0, 0, 3);
    chk_press("s4_load", B_LOAD, ev(0, 0, 3, 0, 0, 0));
    cycles(6);
    sb_push("s4_glitch", ev(0, 0, 3, 0, 0, 0));
    @(negedge clk);
    btn = B_START;
    repeat (2) @(posedge clk);
    @(negedge clk);
    btn = '0;
    cycles(10);
    observe();

    // Asynchronous reset in the middle of a run.
    chk_press("s5_start", B_START, ev(0, 0, 3, 0, 1, 0));
    chk_after("s5_t12", 12, ev(0, 0, 2, 0, 1, 0));
    sb_push("s5_async_reset", ev(0, 0, 0, 0, 0, 0));
    #3;
    reset = 1'b0;
    #1;
    observe();
    chk_after("s5_reset_hold", 2, ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    cycles(6);

    // Start with a zero value is ignored.
    chk_press("s6_start_zero", B_START, ev(0, 0, 0, 0, 0, 0));
    chk_after("s6_still_idle", 12, ev(0, 0, 0, 0, 0, 0));

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
